tick_period_meter: RTL and testbench

Measures the interval, in `clk` cycles, between successive one-cycle event pulses (e.g. the timer's `out` strobe or a debounced input strobe) and presents each interval as a registered result with a valid/ready handshake. It is the receive side of the pulse-interval path: the timer turns a count into a pulse, and this block turns pulses back into a count. Downstream logic (game clock display, move-time limits, self-check of timer programming) consumes the results.

---
 rtl/tick_period_meter.sv | 114 +++++++++++
 tb/tb_tick_period_meter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle interval between successive tick pulses and
// offers each interval as a registered result under valid/ready.
module tick_period_meter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             tick,
  input  logic             clear,
  input  logic             ready,
  output logic [WIDTH-1:0] period,
  output logic             ovf,
  output logic             valid,
  output logic             overrun
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic capture;
  logic accept;
  logic can_load;

  assign capture  = (state_q == MEASURE) & tick;
  assign accept   = valid_q & ready;
  assign can_load = ~valid_q | ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      period_d  = '0;
      ovf_d     = 1'b0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_d = MEASURE;
            count_d = WIDTH'(1);
          end
        end
        MEASURE: begin
          unique case (1'b1)
            capture & can_load: begin
              period_d = count_q;
              ovf_d    = sat_q;
              valid_d  = 1'b1;
              count_d  = WIDTH'(1);
            end
            capture & ~can_load: begin
              overrun_d = 1'b1;
              count_d   = WIDTH'(1);
            end
            default: begin
              if (count_q != MAX) count_d = count_q + WIDTH'(1);
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
      if (accept & ~capture) valid_d = 1'b0;
    end

    // sat tracks a pinned counter, so an interval of exactly MAX reports ovf
    sat_d = (state_d == MEASURE) & (count_d == MAX);
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sat_q     <= 1'b0;
      period_q  <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      period_q  <= period_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign period  = period_q;
  assign ovf     = ovf_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: directed scenarios then random traffic,
// checked against a timestamp-based model of the interval rules.
module tb_tick_period_meter;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         RST;
  logic         tick;
  logic         clear;
  logic         ready;
  logic [W-1:0] period;
  logic         ovf;
  logic         valid;
  logic         overrun;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  bit m_armed = 0;
  int m_t0 = 0;
  bit m_valid = 0;
  int m_period = 0;
  bit m_ovf = 0;
  bit m_overrun = 0;

  tick_period_meter #(.WIDTH(W)) dut (
    .clk(clk),
    .RST(RST),
    .tick(tick),
    .clear(clear),
    .ready(ready),
    .period(period),
    .ovf(ovf),
    .valid(valid),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit t, input bit c, input bit r, input bit rs);
    int iv;
    bit cap;
    if (!rs || c) begin
      m_armed = 0;
      m_valid = 0;
      m_period = 0;
      m_ovf = 0;
      m_overrun = 0;
    end else begin
      cap = t && m_armed;
      if (cap) begin
        iv = cyc - m_t0;
        if (!m_valid || r) begin
          m_period = (iv > MAXV) ? MAXV : iv;
          m_ovf = (iv >= MAXV);
          m_valid = 1;
        end else begin
          m_overrun = 1;
        end
        m_t0 = cyc;
      end else if (m_valid && r) begin
        m_valid = 0;
      end
      if (t && !m_armed) begin
        m_armed = 1;
        m_t0 = cyc;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit t, input bit c, input bit r, input bit rs);
    tick = t;
    clear = c;
    ready = r;
    RST = rs;
    @(posedge clk);
    model_edge(t, c, r, rs);
    #1;
    chk("valid", int'(valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_overrun));
    if (m_valid) begin
      chk("period", int'(period), m_period);
      chk("ovf", int'(ovf), int'(m_ovf));
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, r, 1);
  endtask

  initial begin
    int p_tick;
    int p_rdy;
    tick = 0;
    clear = 0;
    ready = 0;
    RST = 0;

    // reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_overrun", int'(overrun), 0);

    // arm then first result of 4
    idle(2, 1);
    step(1, 0, 1, 1);
    chk("arm_no_valid", int'(valid), 0);
    idle(3, 1);
    step(1, 0, 1, 1);
    chk("first_valid", int'(valid), 1);
    chk("first_period", int'(period), 4);
    chk("first_ovf", int'(ovf), 0);
    idle(1, 1);
    chk("first_drop", int'(valid), 0);

    // consecutive ticks after a clear
    step(0, 1, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    chk("consec1_period", int'(period), 1);
    step(1, 0, 1, 1);
    chk("consec2_valid", int'(valid), 1);
    chk("consec2_period", int'(period), 1);
    chk("consec_overrun", int'(overrun), 0);
    idle(1, 1);

    // backpressure and overrun
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    idle(2, 0);
    step(1, 0, 0, 1);
    idle(4, 0);
    chk("bp_held_period", int'(period), 3);
    step(1, 0, 0, 1);
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_still_period", int'(period), 3);
    step(0, 0, 1, 1);
    chk("bp_accept", int'(valid), 0);
    chk("bp_overrun_sticky", int'(overrun), 1);

    // accept and capture in the same cycle
    step(0, 1, 0, 1);
    step(1, 0, 0, 1);
    idle(2, 0);
    step(1, 0, 0, 1);
    idle(5, 0);
    step(1, 0, 1, 1);
    chk("ac_valid", int'(valid), 1);
    chk("ac_period", int'(period), 6);
    chk("ac_overrun", int'(overrun), 0);

    // saturation then a normal interval
    step(0, 1, 1, 1);
    step(1, 0, 1, 1);
    idle(19, 1);
    step(1, 0, 1, 1);
    chk("sat_period", int'(period), 15);
    chk("sat_ovf", int'(ovf), 1);
    idle(6, 1);
    step(1, 0, 1, 1);
    chk("post_sat_period", int'(period), 7);
    chk("post_sat_ovf", int'(ovf), 0);

    // exact max interval
    idle(14, 1);
    step(1, 0, 1, 1);
    chk("max_period", int'(period), 15);
    chk("max_ovf", int'(ovf), 1);

    // reset mid measurement
    step(1, 0, 1, 1);
    idle(3, 1);
    step(0, 0, 1, 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_period", int'(period), 0);
    step(1, 0, 1, 1);
    idle(1, 1);
    chk("midrst_rearm", int'(valid), 0);

    // clear coinciding with a tick, with pending result and overrun
    idle(2, 0);
    step(1, 0, 0, 1);
    idle(1, 0);
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    chk("clr_valid", int'(valid), 0);
    chk("clr_overrun", int'(overrun), 0);
    idle(2, 1);
    step(1, 0, 1, 1);
    chk("clr_arm_only", int'(valid), 0);
    idle(2, 1);
    step(1, 0, 1, 1);
    chk("clr_next_period", int'(period), 3);

    // random traffic
    p_tick = 20;
    p_rdy = 70;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: p_tick = 3;
          1: p_tick = 12;
          2: p_tick = 50;
          default: p_tick = 95;
        endcase
        p_rdy = $urandom_range(10, 100);
      end
      step($urandom_range(0, 99) < p_tick,
           $urandom_range(0, 399) == 0,
           $urandom_range(0, 99) < p_rdy,
           $urandom_range(0, 999) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
